// File: rtl/pong_physics.sv
// pong_physics: ball and paddle motion engine for the Pong datapath.
// All motion advances on tick cycles while stop is low; outputs are registered.
// Optional build macro SPEEDUP_EN: the ball step grows by one on every 4th
// paddle hit (up to BALL_STEP+3) and falls back to BALL_STEP when a point is lost.
module pong_physics #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_W    = 8,
    parameter int P1_X        = 16,
    parameter int P2_X        = 616,
    parameter int PADDLE_STEP = 4,
    parameter int BALL_STEP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       stop,
    input  logic       serve,
    input  logic       up1,
    input  logic       down1,
    input  logic       up2,
    input  logic       down2,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic       miss1,
    output logic       miss2,
    output logic       hit
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_MISSED = 2'd2
    } state_t;

    localparam logic [9:0] BALL_X0     = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0     = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0] PAD_Y0      = 10'((V_RES - PADDLE_H) / 2);
    localparam logic [9:0] PAD_MAX     = 10'(V_RES - PADDLE_H);
    localparam logic [9:0] PAD_STEP_V  = 10'(PADDLE_STEP);
    localparam logic [9:0] X_MAX       = 10'(H_RES - BALL_SIZE);
    localparam logic [9:0] P1_BOUNCE_X = 10'(P1_X + PADDLE_W);
    localparam logic [9:0] P2_BOUNCE_X = 10'(P2_X - BALL_SIZE);
    localparam logic [2:0] STEP_BASE   = 3'(BALL_STEP);

    localparam logic signed [10:0] X_MAX_S  = 11'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX_S  = 11'(V_RES - BALL_SIZE);
    localparam logic signed [10:0] P1_X_S   = 11'(P1_X);
    localparam logic signed [10:0] P2_X_S   = 11'(P2_X);
    localparam logic signed [10:0] PAD_W_S  = 11'(PADDLE_W);
    localparam logic signed [10:0] PAD_H_S  = 11'(PADDLE_H);
    localparam logic signed [10:0] BALL_S_S = 11'(BALL_SIZE);

    // Paddle position after one step; opposing keys cancel, travel saturates.
    function automatic logic [9:0] paddle_next(input logic [9:0] pos,
                                               input logic up,
                                               input logic down);
        logic [9:0] res;
        if (up && !down) begin
            if (pos < PAD_STEP_V) res = 10'd0;
            else                  res = pos - PAD_STEP_V;
        end else if (down && !up) begin
            if (pos > PAD_MAX - PAD_STEP_V) res = PAD_MAX;
            else                            res = pos + PAD_STEP_V;
        end else begin
            res = pos;
        end
        return res;
    endfunction

    // True when the intervals [a, a+a_len) and [b, b+b_len) share any pixel.
    function automatic logic spans(input logic signed [10:0] a,
                                   input logic signed [10:0] a_len,
                                   input logic signed [10:0] b,
                                   input logic signed [10:0] b_len);
        return (a < b + b_len) && (b < a + a_len);
    endfunction

    state_t             state_r, state_n_s;
    logic [9:0]         ball_x_r, ball_x_n_s;
    logic [9:0]         ball_y_r, ball_y_n_s;
    logic [9:0]         pad1_r, pad1_n_s;
    logic [9:0]         pad2_r, pad2_n_s;
    logic               dx_pos_r, dx_pos_n_s;
    logic               dy_pos_r, dy_pos_n_s;
    logic               miss1_r, miss1_n_s;
    logic               miss2_r, miss2_n_s;
    logic               hit_r, hit_n_s;
    logic               move_s;
    logic [2:0]         step_s;
    logic signed [10:0] step_x_s;
    logic signed [10:0] nx_s;
    logic signed [10:0] ny_s;
    logic signed [10:0] y_new_s;
    logic signed [10:0] pad1_ext_s;
    logic signed [10:0] pad2_ext_s;

    assign move_s     = tick && !stop;
    assign step_x_s   = signed'({8'd0, step_s});
    assign nx_s       = signed'({1'b0, ball_x_r}) + (dx_pos_r ? step_x_s : -step_x_s);
    assign ny_s       = signed'({1'b0, ball_y_r}) + (dy_pos_r ? step_x_s : -step_x_s);
    assign pad1_ext_s = signed'({1'b0, pad1_r});
    assign pad2_ext_s = signed'({1'b0, pad2_r});

`ifdef SPEEDUP_EN
    logic [2:0] hit_cnt_r;
    logic [2:0] step_r;
    logic [2:0] hit_cnt_inc_s;
    logic       miss_entry_s;

    localparam logic [2:0] STEP_MAX = 3'(BALL_STEP + 3);

    assign hit_cnt_inc_s = hit_cnt_r + 3'd1;
    assign miss_entry_s  = (state_n_s == ST_MISSED) && (state_r != ST_MISSED);
    assign step_s        = step_r;

    // Count paddle hits and raise the ball step on every 4th; a lost point restarts both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_r <= 3'd0;
            step_r    <= STEP_BASE;
        end else if (miss_entry_s) begin
            hit_cnt_r <= 3'd0;
            step_r    <= STEP_BASE;
        end else if (hit_n_s) begin
            hit_cnt_r <= hit_cnt_inc_s;
            if ((hit_cnt_inc_s[1:0] == 2'b00) && (step_r < STEP_MAX)) begin
                step_r <= step_r + 3'd1;
            end else begin
                step_r <= step_r;
            end
        end else begin
            hit_cnt_r <= hit_cnt_r;
            step_r    <= step_r;
        end
    end
`else
    assign step_s = STEP_BASE;
`endif

    // Next-state logic: paddle steps, ball move with wall/paddle/miss resolution, pulses.
    always_comb begin
        state_n_s  = state_r;
        ball_x_n_s = ball_x_r;
        ball_y_n_s = ball_y_r;
        dx_pos_n_s = dx_pos_r;
        dy_pos_n_s = dy_pos_r;
        pad1_n_s   = pad1_r;
        pad2_n_s   = pad2_r;
        miss1_n_s  = 1'b0;
        miss2_n_s  = 1'b0;
        hit_n_s    = 1'b0;
        y_new_s    = ny_s;

        if (move_s) begin
            pad1_n_s = paddle_next(pad1_r, up1, down1);
            pad2_n_s = paddle_next(pad2_r, up2, down2);
        end else begin
            pad1_n_s = pad1_r;
            pad2_n_s = pad2_r;
        end

        case (state_r)
            ST_IDLE: begin
                ball_x_n_s = BALL_X0;
                ball_y_n_s = BALL_Y0;
                if (serve) state_n_s = ST_MOVE;
                else       state_n_s = ST_IDLE;
            end
            ST_MOVE: begin
                if (move_s) begin
                    // Walls first so the paddle test sees the clamped height.
                    if (ny_s <= 11'sd0) begin
                        y_new_s    = 11'sd0;
                        dy_pos_n_s = 1'b1;
                    end else if (ny_s >= Y_MAX_S) begin
                        y_new_s    = Y_MAX_S;
                        dy_pos_n_s = 1'b0;
                    end else begin
                        y_new_s = ny_s;
                    end
                    ball_y_n_s = y_new_s[9:0];

                    // Paddle contact wins over a miss on the same tick.
                    if (!dx_pos_r && spans(nx_s, BALL_S_S, P1_X_S, PAD_W_S)
                                  && spans(y_new_s, BALL_S_S, pad1_ext_s, PAD_H_S)) begin
                        ball_x_n_s = P1_BOUNCE_X;
                        dx_pos_n_s = 1'b1;
                        hit_n_s    = 1'b1;
                    end else if (dx_pos_r && spans(nx_s, BALL_S_S, P2_X_S, PAD_W_S)
                                          && spans(y_new_s, BALL_S_S, pad2_ext_s, PAD_H_S)) begin
                        ball_x_n_s = P2_BOUNCE_X;
                        dx_pos_n_s = 1'b0;
                        hit_n_s    = 1'b1;
                    end else if (nx_s <= 11'sd0) begin
                        // Player 2 scored; relaunch toward player 2.
                        ball_x_n_s = 10'd0;
                        dx_pos_n_s = 1'b1;
                        miss1_n_s  = 1'b1;
                        state_n_s  = ST_MISSED;
                    end else if (nx_s >= X_MAX_S) begin
                        ball_x_n_s = X_MAX;
                        dx_pos_n_s = 1'b0;
                        miss2_n_s  = 1'b1;
                        state_n_s  = ST_MISSED;
                    end else begin
                        ball_x_n_s = nx_s[9:0];
                    end
                end else begin
                    ball_x_n_s = ball_x_r;
                    ball_y_n_s = ball_y_r;
                end
            end
            ST_MISSED: begin
                if (serve) begin
                    ball_x_n_s = BALL_X0;
                    ball_y_n_s = BALL_Y0;
                    state_n_s  = ST_MOVE;
                end else begin
                    state_n_s = ST_MISSED;
                end
            end
            default: begin
                state_n_s  = ST_IDLE;
                ball_x_n_s = BALL_X0;
                ball_y_n_s = BALL_Y0;
            end
        endcase
    end

    // State, position, direction and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ball_x_r <= BALL_X0;
            ball_y_r <= BALL_Y0;
            pad1_r   <= PAD_Y0;
            pad2_r   <= PAD_Y0;
            dx_pos_r <= 1'b1;
            dy_pos_r <= 1'b1;
            miss1_r  <= 1'b0;
            miss2_r  <= 1'b0;
            hit_r    <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            ball_x_r <= ball_x_n_s;
            ball_y_r <= ball_y_n_s;
            pad1_r   <= pad1_n_s;
            pad2_r   <= pad2_n_s;
            dx_pos_r <= dx_pos_n_s;
            dy_pos_r <= dy_pos_n_s;
            miss1_r  <= miss1_n_s;
            miss2_r  <= miss2_n_s;
            hit_r    <= hit_n_s;
        end
    end

    assign ball_x    = ball_x_r;
    assign ball_y    = ball_y_r;
    assign paddle1_y = pad1_r;
    assign paddle2_y = pad2_r;
    assign miss1     = miss1_r;
    assign miss2     = miss2_r;
    assign hit       = hit_r;

endmodule

// File: tb/tb_pong_physics.sv
// Testbench for pong_physics: directed scenarios plus randomized play, checked
// every cycle against a behavioural game model kept in plain integer arithmetic.
`timescale 1ns/1ps
module tb_pong_physics;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, stop = 1'b0, serve = 1'b0;
    logic       up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
    logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
    logic       miss1, miss2, hit;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    localparam int S_IDLE = 0, S_MOVE = 1, S_MISSED = 2;

    // Model of the game, in screen pixels.
    int m_state, m_bx, m_by, m_p1, m_p2, m_dx, m_dy, m_hits;
    bit e_hit, e_m1, e_m2;

    pong_physics dut (
        .clk(clk), .rst(rst), .tick(tick), .stop(stop), .serve(serve),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2),
        .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
        .miss1(miss1), .miss2(miss2), .hit(hit)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit spans(input int a, input int alen, input int b, input int blen);
        return (a < b + blen) && (b < a + alen);
    endfunction

    function automatic int speed();
`ifdef SPEEDUP_EN
        return (2 + m_hits / 4 > 5) ? 5 : 2 + m_hits / 4;
`else
        return 2;
`endif
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_bx = 316; m_by = 236; m_p1 = 208; m_p2 = 208;
        m_dx = 1; m_dy = 1; m_hits = 0; e_hit = 0; e_m1 = 0; e_m2 = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT sees at this edge.
    task automatic model_clk();
        int nx, ny, sp, p1o, p2o;
        bit mv;
        e_hit = 0; e_m1 = 0; e_m2 = 0;
        if (rst) begin
            model_reset();
            return;
        end
        mv  = tick && !stop;
        sp  = speed();
        p1o = m_p1;
        p2o = m_p2;
        if (mv) begin
            m_p1 = clamp(m_p1 + 4 * (int'(down1) - int'(up1)), 0, 416);
            m_p2 = clamp(m_p2 + 4 * (int'(down2) - int'(up2)), 0, 416);
        end
        if (m_state == S_IDLE) begin
            if (serve) m_state = S_MOVE;
        end else if (m_state == S_MISSED) begin
            if (serve) begin m_bx = 316; m_by = 236; m_state = S_MOVE; end
        end else if (mv) begin
            nx = m_bx + m_dx * sp;
            ny = m_by + m_dy * sp;
            if (ny <= 0)        begin ny = 0;   m_dy = 1;  end
            else if (ny >= 472) begin ny = 472; m_dy = -1; end
            m_by = ny;
            if (m_dx < 0 && spans(nx, 8, 16, 8) && spans(ny, 8, p1o, 64)) begin
                m_bx = 24; m_dx = 1; e_hit = 1; m_hits++;
            end else if (m_dx > 0 && spans(nx, 8, 616, 8) && spans(ny, 8, p2o, 64)) begin
                m_bx = 608; m_dx = -1; e_hit = 1; m_hits++;
            end else if (nx <= 0) begin
                m_bx = 0; m_dx = 1; e_m1 = 1; m_state = S_MISSED; m_hits = 0;
            end else if (nx >= 632) begin
                m_bx = 632; m_dx = -1; e_m2 = 1; m_state = S_MISSED; m_hits = 0;
            end else begin
                m_bx = nx;
            end
        end
    endtask

    // One clock: drive inputs just after an edge, step the model at the next edge.
    task automatic cyc(input bit t, input bit s, input bit sv,
                       input bit u1v, input bit d1v, input bit u2v, input bit d2v);
        tick = t; stop = s; serve = sv; up1 = u1v; down1 = d1v; up2 = u2v; down2 = d2v;
        @(posedge clk);
        model_clk();
        #1;
    endtask

    // Compare every DUT output to the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ball_x", int'(ball_x), m_bx);
            chk("ball_y", int'(ball_y), m_by);
            chk("paddle1_y", int'(paddle1_y), m_p1);
            chk("paddle2_y", int'(paddle2_y), m_p2);
            chk("miss1", int'(miss1), int'(e_m1));
            chk("miss2", int'(miss2), int'(e_m2));
            chk("hit", int'(hit), int'(e_hit));
        end
    end

    initial begin
        bit t1u, t1d, t2u, t2d, seen, r_u1, r_d1, r_u2, r_d2, r_stop;
        int mx, my, p1s, p2s, sp_exp;

        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reset values.
        chk("rst_ball_x", int'(ball_x), 316);
        chk("rst_ball_y", int'(ball_y), 236);
        chk("rst_pad1", int'(paddle1_y), 208);
        chk("rst_pad2", int'(paddle2_y), 208);
        chk("rst_pulses", int'({miss1, miss2, hit}), 0);

        // No serve: ball stays at centre.
        repeat (20) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("idle_ball_x", int'(ball_x), 316);
        chk("idle_ball_y", int'(ball_y), 236);

        // Serve then 10 ticks.
        cyc(0, 0, 1, 0, 0, 0, 0);
        repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("serve10_x", int'(ball_x), 336);
        chk("serve10_y", int'(ball_y), 256);

        // Bottom wall: reach 472, then the next tick must move up.
        for (int i = 0; i < 300 && m_by != 472; i++) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("wall_reach_y", int'(ball_y), 472);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("wall_bounce_y", int'(ball_y), 470);

        // Paddle saturation and cancelling keys.
        repeat (60) cyc(1, 0, 0, 1, 0, 0, 0);
        chk("pad1_top", int'(paddle1_y), 0);
        repeat (60) cyc(1, 0, 0, 0, 0, 0, 1);
        chk("pad2_bottom", int'(paddle2_y), 416);
        repeat (5) cyc(1, 0, 0, 0, 1, 0, 0);
        chk("pad1_down5", int'(paddle1_y), 20);
        repeat (10) cyc(1, 0, 0, 1, 1, 0, 0);
        chk("pad1_both_keys", int'(paddle1_y), 20);

        // Rally with both paddles tracking until a left-paddle hit.
        seen = 0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            t1u = (m_p1 + 32 > m_by + 6); t1d = (m_p1 + 32 < m_by + 2);
            t2u = (m_p2 + 32 > m_by + 6); t2d = (m_p2 + 32 < m_by + 2);
            cyc(1, 0, m_state != S_MOVE, t1u, t1d, t2u, t2d);
            if (e_hit && m_bx == 24) begin
                seen = 1;
                chk("hit_left_x", int'(ball_x), 24);
                chk("hit_left_pulse", int'(hit), 1);
            end
        end
        chk("left_hit_seen", int'(seen), 1);

`ifdef SPEEDUP_EN
        // Keep rallying until a hit count that is a multiple of four.
        seen = 0;
        for (int i = 0; i < 8000 && !seen; i++) begin
            t1u = (m_p1 + 32 > m_by + 6); t1d = (m_p1 + 32 < m_by + 2);
            t2u = (m_p2 + 32 > m_by + 6); t2d = (m_p2 + 32 < m_by + 2);
            cyc(1, 0, m_state != S_MOVE, t1u, t1d, t2u, t2d);
            if (e_hit && m_hits > 0 && m_hits % 4 == 0) seen = 1;
        end
        chk("speedup_hits_seen", int'(seen), 1);
        mx = m_bx;
        sp_exp = (m_hits == 4) ? 3 : ((m_hits == 8) ? 4 : 5);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("speedup_delta", (int'(ball_x) > mx) ? int'(ball_x) - mx : mx - int'(ball_x), sp_exp);
`endif

        // Left paddle parked at the bottom until player 1 misses.
        seen = 0;
        for (int i = 0; i < 8000 && !seen; i++) begin
            t2u = (m_p2 + 32 > m_by + 6); t2d = (m_p2 + 32 < m_by + 2);
            cyc(1, 0, m_state != S_MOVE, 0, 1, t2u, t2d);
            if (e_m1) seen = 1;
        end
        chk("miss1_seen", int'(seen), 1);
        chk("miss1_x", int'(ball_x), 0);
        chk("miss1_pulse", int'(miss1), 1);
        repeat (5) cyc(1, 0, 0, 0, 0, 0, 0);
        chk("missed_frozen_x", int'(ball_x), 0);
        chk("miss1_once", int'(miss1), 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("reserve_x", int'(ball_x), 316);
        chk("reserve_y", int'(ball_y), 236);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("reserve_move_right", int'(ball_x), 318);

        // Stop mid-flight: everything holds, then motion resumes rightwards.
        mx = m_bx; my = m_by; p1s = m_p1; p2s = m_p2;
        repeat (5) cyc(1, 1, 0, 1, 0, 0, 1);
        chk("stop_x", int'(ball_x), mx);
        chk("stop_y", int'(ball_y), my);
        chk("stop_p1", int'(paddle1_y), p1s);
        chk("stop_p2", int'(paddle2_y), p2s);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("resume_x", int'(ball_x), mx + 2);

        // Randomized play with one asynchronous reset in the middle.
        r_u1 = 0; r_d1 = 0; r_u2 = 0; r_d2 = 0; r_stop = 0;
        for (int i = 0; i < 8000; i++) begin
            if (i == 4000) begin
                rst = 1'b1;
                model_reset();
                repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
                rst = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin r_u1 = $urandom_range(0, 1) != 0; r_d1 = $urandom_range(0, 1) != 0; end
            if ($urandom_range(0, 7) == 0) begin r_u2 = $urandom_range(0, 1) != 0; r_d2 = $urandom_range(0, 1) != 0; end
            if ($urandom_range(0, 29) == 0) r_stop = !r_stop;
            cyc($urandom_range(0, 1) != 0, r_stop, $urandom_range(0, 19) == 0, r_u1, r_d1, r_u2, r_d2);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
